// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared state encoding, control-word layout and datapath opcodes
package alu_seq_ctrl_pkg;

    localparam logic [31:0] IDLE_DISP = 32'h8888_8888;

    typedef enum logic [2:0] {
        ST_LD_A,
        ST_LD_SD,
        ST_LD_CTL,
        ST_EXEC,
        ST_OUT_F,
        ST_OUT_SH
    } state_t;

    // Control word: [31:24] sh_num, [23:21] sh_op, [20:17] alu_op, [16] cf_in, [15] vf_in
    localparam int CTL_SH_NUM_LSB = 24;
    localparam int CTL_SH_OP_LSB  = 21;
    localparam int CTL_ALU_OP_LSB = 17;
    localparam int CTL_CF_BIT     = 16;
    localparam int CTL_VF_BIT     = 15;

    // Field order matches the control word so bits [31:15] cast straight in
    typedef struct packed {
        logic [7:0] sh_num;
        logic [2:0] sh_op;
        logic [3:0] alu_op;
        logic       cf_in;
        logic       vf_in;
    } ctl_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_ORR = 4'd3;
    localparam logic [3:0] ALU_EOR = 4'd4;
    localparam logic [3:0] ALU_ADC = 4'd5;

    localparam logic [2:0] SH_LSL = 3'd0;
    localparam logic [2:0] SH_LSR = 3'd1;
    localparam logic [2:0] SH_ASR = 3'd2;
    localparam logic [2:0] SH_ROR = 3'd3;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - operand beat stream in, result beat stream out
interface alu_seq_ctrl_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequences A / shift-data / control beats into an external ALU+shifter
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_ctrl_if.slave bus,
    input  logic          abort,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] sh_data,
    output logic [7:0]    sh_num,
    output logic [2:0]    sh_op,
    output logic [3:0]    alu_op,
    output logic          cf_in,
    output logic          vf_in,
    input  logic [DW-1:0] alu_f,
    input  logic [3:0]    alu_nzcv,
    input  logic [DW-1:0] sh_out,
    input  logic          sh_cout,
    output logic [4:0]    flags,
    output logic [1:0]    beat_cnt,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] sh_data_q, sh_data_d;
    ctl_t          ctl_q, ctl_d;
    logic [DW-1:0] sh_res_q, sh_res_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [4:0]    flags_q, flags_d;

    logic       in_ready_c, out_valid_c, out_last_c, busy_c;
    logic [1:0] beat_cnt_c;
    logic       in_fire, out_fire;

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        busy_c      = 1'b0;
        beat_cnt_c  = 2'd3;
        case (state_q)
            ST_LD_A: begin
                in_ready_c = 1'b1;
                beat_cnt_c = 2'd0;
                if (bus.in_valid) state_d = ST_LD_SD;
            end
            ST_LD_SD: begin
                in_ready_c = 1'b1;
                beat_cnt_c = 2'd1;
                if (bus.in_valid) state_d = ST_LD_CTL;
            end
            ST_LD_CTL: begin
                in_ready_c = 1'b1;
                beat_cnt_c = 2'd2;
                if (bus.in_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                busy_c  = 1'b1;
                state_d = ST_OUT_F;
            end
            ST_OUT_F: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = ST_OUT_SH;
            end
            ST_OUT_SH: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                out_last_c  = 1'b1;
                if (bus.out_ready) state_d = ST_LD_A;
            end
            default: state_d = ST_LD_A;
        endcase
        // Abort overrides any handshake completing in the same cycle
        if (abort) state_d = ST_LD_A;
    end

    assign in_fire  = in_ready_c  & bus.in_valid  & ~abort;
    assign out_fire = out_valid_c & bus.out_ready & ~abort;

    always_comb begin
        alu_a_d    = alu_a_q;
        sh_data_d  = sh_data_q;
        ctl_d      = ctl_q;
        sh_res_d   = sh_res_q;
        out_data_d = out_data_q;
        flags_d    = flags_q;
        if (in_fire && state_q == ST_LD_A)   alu_a_d   = bus.in_data;
        if (in_fire && state_q == ST_LD_SD)  sh_data_d = bus.in_data;
        if (in_fire && state_q == ST_LD_CTL) ctl_d     = ctl_t'(bus.in_data[DW-1:CTL_VF_BIT]);
        if (state_q == ST_EXEC && !abort) begin
            sh_res_d   = sh_out;
            out_data_d = alu_f;
            flags_d    = {alu_nzcv, sh_cout};
        end
        if (out_fire && state_q == ST_OUT_F) out_data_d = sh_res_q;
        if (abort) out_data_d = IDLE_DISP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LD_A;
            alu_a_q    <= '0;
            sh_data_q  <= '0;
            ctl_q      <= '0;
            sh_res_q   <= '0;
            out_data_q <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            sh_data_q  <= sh_data_d;
            ctl_q      <= ctl_d;
            sh_res_q   <= sh_res_d;
            out_data_q <= out_data_d;
            flags_q    <= flags_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    assign bus.out_data  = out_data_q;
    assign alu_a    = alu_a_q;
    assign sh_data  = sh_data_q;
    assign sh_num   = ctl_q.sh_num;
    assign sh_op    = ctl_q.sh_op;
    assign alu_op   = ctl_q.alu_op;
    assign cf_in    = ctl_q.cf_in;
    assign vf_in    = ctl_q.vf_in;
    assign flags    = flags_q;
    assign beat_cnt = beat_cnt_c;
    assign busy     = busy_c;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: DW, 32, operand/result width; only 32 supported.
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: in_valid / in_ready / in_data  in/out/in  1/1/32  operand beat stream, valid/ready handshake.
REQ-005 Port: abort  in  1  synchronous command abort.
REQ-006 Port: alu_a, sh_data  out  32 each  registered operands to ALU / shifter.
REQ-007 Port: sh_num 8, sh_op 3, alu_op 4, cf_in 1, vf_in 1  out  registered control to datapath.
REQ-008 Port: alu_f 32, alu_nzcv 4, sh_out 32, sh_cout 1  in  combinational datapath results.
REQ-009 Port: out_valid / out_ready / out_data / out_last  out/in/out/out  1/1/32/1  result stream.
REQ-010 Port: flags  out  5  latched {NZCV, shift carry}; beat_cnt out 2 operand beats accepted; busy out 1.

Function
REQ-011 FSM states SHALL be LD_A, LD_SD, LD_CTL, EXEC, OUT_F, OUT_SH.
REQ-012 in_ready SHALL be 1 only in LD_A, LD_SD, LD_CTL; accepting a beat advances one state.
REQ-013 LD_A beat -> alu_a; LD_SD beat -> sh_data; LD_CTL beat -> sh_num=[31:24], sh_op=[23:21], alu_op=[20:17], cf_in=[16], vf_in=[15]; bits [14:0] ignored.
REQ-014 EXEC SHALL last exactly one cycle; at its end alu_f, sh_out, {alu_nzcv, sh_cout} SHALL be captured into result registers and flags.
REQ-015 OUT_F: out_valid=1, out_data=captured F, out_last=0; on out_ready -> OUT_SH.
REQ-016 OUT_SH: out_valid=1, out_data=captured shift result, out_last=1; on out_ready -> LD_A.
REQ-017 out_valid/out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 Latency: CTL beat accepted at cycle N -> out_valid asserted at cycle N+2.
REQ-019 Operand/control registers SHALL hold unchanged from CTL acceptance until next LD_A beat accepted.
REQ-020 beat_cnt SHALL be 0/1/2 in LD_A/LD_SD/LD_CTL and 3 elsewhere (wraps to 0 on return to LD_A).
REQ-021 busy SHALL be 1 in EXEC, OUT_F, OUT_SH.
REQ-022 abort=1 in any state SHALL force LD_A next cycle, drop out_valid, leave flags unchanged; abort wins over a simultaneous in or out handshake (beat not consumed).
REQ-023 out_ready held 1 continuously SHALL yield back-to-back beats F then shift, one per cycle.
REQ-024 Both handshakes SHALL be ignored while the respective valid/ready is 0; no combinational path from in_valid to in_ready.

Reset
REQ-025 rst_n=0 SHALL immediately force LD_A, in_ready=1 after release, out_valid=0, out_last=0, busy=0, beat_cnt=0.
REQ-026 Reset SHALL clear alu_a, sh_data, sh_num, sh_op, alu_op, cf_in, vf_in, out_data, flags to 0.
REQ-027 Reset asserted mid-command SHALL discard the partial command; first beat after release is A.

Structure
REQ-028 Shared package SHALL hold state encoding, control-word field positions, and error/idle display constant 32'h88888888.
REQ-029 Single module, no sub-modules; ALU and shifter instantiated by the parent, not inside this block.

Verification
REQ-030 Beats A=0x00000005, SD=0x00000003, CTL with ADD, shift LSL #0 -> out F=0x00000008 (out_last=0), then 0x00000003 (out_last=1), out_valid at N+2.
REQ-031 out_ready=0 for 5 cycles in OUT_F -> out_data stable 0x00000008, no state change; then ready -> two beats delivered.
REQ-032 abort asserted in LD_CTL with in_valid=1 -> beat not consumed, beat_cnt=0, next beat loads alu_a.
REQ-033 rst_n low during OUT_SH -> out_valid=0 immediately, all outputs zero; fresh 3-beat command completes correctly.
REQ-034 Result causing zero (A=0x80000000 + 0x80000000) -> flags NZCV=0111 held through next command's load phase.
REQ-035 Back-to-back commands with in_valid/out_ready tied 1 -> 6-cycle command period, no dropped or duplicated beats.
